// File: rtl/bcd_multi_counter.sv
// Multi-digit BCD up/down counter with parallel load, wrap/saturate limit handling
// and a registered terminal-count pulse for cascading.
module bcd_multi_counter #(
    parameter int DIGITS   = 2,
    parameter bit SATURATE = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                up,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    output logic [4*DIGITS-1:0] count,
    output logic                tc
);

    logic [4*DIGITS-1:0] r_count;
    logic                r_tc;
    logic [4*DIGITS-1:0] w_step;
    logic [4*DIGITS-1:0] w_clean;
    logic                w_carry;
    logic [3:0]          w_nib;

    // Ripple through the digits in one cycle; a carry/borrow surviving past the
    // top digit means the counter was sitting at its limit for this direction.
    always_comb begin
        w_step  = r_count;
        w_carry = 1'b1;
        w_nib   = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            w_nib = r_count[4*i +: 4];
            if (w_carry) begin
                if (up) begin
                    if (w_nib == 4'd9) begin
                        w_step[4*i +: 4] = 4'd0;
                    end else begin
                        w_step[4*i +: 4] = w_nib + 4'd1;
                        w_carry          = 1'b0;
                    end
                end else begin
                    if (w_nib == 4'd0) begin
                        w_step[4*i +: 4] = 4'd9;
                    end else begin
                        w_step[4*i +: 4] = w_nib - 4'd1;
                        w_carry          = 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        w_clean = load_val;
        for (int i = 0; i < DIGITS; i++) begin
            if (load_val[4*i +: 4] > 4'd9) begin
                w_clean[4*i +: 4] = 4'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
            r_tc    <= 1'b0;
        end else if (load) begin
            r_count <= w_clean;
            r_tc    <= 1'b0;
        end else if (en) begin
            r_tc <= w_carry;
            if (!(SATURATE && w_carry)) begin
                r_count <= w_step;
            end
        end else begin
            r_tc <= 1'b0;
        end
    end

    assign count = r_count;
    assign tc    = r_tc;

endmodule

// File: tb/tb_bcd_multi_counter.sv
// Bench for bcd_multi_counter: 2-digit wrap, 2-digit saturate and 4-digit wrap
// instances share stimulus and are checked against an integer reference model.
module tb_bcd_multi_counter;

    logic        clk = 1'b0;
    logic        rst_n, en, up, load;
    logic [15:0] ld;
    logic [7:0]  c2w, c2s;
    logic [15:0] c4;
    logic        t2w, t2s, t4;

    int checks = 0;
    int errors = 0;

    int m_val [3];
    int m_tc  [3];
    int m_mod [3] = '{100, 100, 10000};
    int m_sat [3] = '{0, 1, 0};
    int m_nd  [3] = '{2, 2, 4};

    always #5 clk = ~clk;

    bcd_multi_counter #(.DIGITS(2), .SATURATE(1'b0)) u2w (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
        .load_val(ld[7:0]), .count(c2w), .tc(t2w));
    bcd_multi_counter #(.DIGITS(2), .SATURATE(1'b1)) u2s (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
        .load_val(ld[7:0]), .count(c2s), .tc(t2s));
    bcd_multi_counter #(.DIGITS(4), .SATURATE(1'b0)) u4w (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
        .load_val(ld), .count(c4), .tc(t4));

    function automatic int bcd2int(input logic [15:0] b, input int nd);
        int v = 0;
        for (int i = nd - 1; i >= 0; i--) begin
            int d = int'(b[4*i +: 4]);
            v = v * 10 + ((d > 9) ? 0 : d);
        end
        return v;
    endfunction

    function automatic logic [15:0] int2bcd(input int v);
        logic [15:0] b = '0;
        int x = v;
        for (int i = 0; i < 4; i++) begin
            b[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return b;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                m_val[k] = 0; m_tc[k] = 0;
            end else if (load) begin
                m_val[k] = bcd2int(ld, m_nd[k]); m_tc[k] = 0;
            end else if (en) begin
                if (up) begin
                    if (m_val[k] == m_mod[k] - 1) begin
                        m_tc[k] = 1;
                        if (m_sat[k] == 0) m_val[k] = 0;
                    end else begin
                        m_val[k]++; m_tc[k] = 0;
                    end
                end else begin
                    if (m_val[k] == 0) begin
                        m_tc[k] = 1;
                        if (m_sat[k] == 0) m_val[k] = m_mod[k] - 1;
                    end else begin
                        m_val[k]--; m_tc[k] = 0;
                    end
                end
            end else begin
                m_tc[k] = 0;
            end
        end
    endtask

    task automatic step(input logic r, input logic e, input logic u, input logic l,
                        input logic [15:0] d);
        rst_n = r; en = e; up = u; load = l; ld = d;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, " c2w"}, {24'd0, c2w}, {16'd0, int2bcd(m_val[0])});
        chk({tag, " t2w"}, {31'd0, t2w}, 32'(m_tc[0]));
        chk({tag, " c2s"}, {24'd0, c2s}, {16'd0, int2bcd(m_val[1])});
        chk({tag, " t2s"}, {31'd0, t2s}, 32'(m_tc[1]));
        chk({tag, " c4"},  {16'd0, c4},  {16'd0, int2bcd(m_val[2])});
        chk({tag, " t4"},  {31'd0, t4},  32'(m_tc[2]));
    endtask

    typedef struct {
        logic        r, e, u, l;
        logic [15:0] d;
        logic [7:0]  e2w; logic t2w;
        logic [7:0]  e2s; logic t2s;
    } vec_t;

    vec_t vt [15];

    initial begin
        vt[0]  = '{1'b0,1'b1,1'b1,1'b1,16'h0055, 8'h00,1'b0, 8'h00,1'b0};
        vt[1]  = '{1'b1,1'b0,1'b1,1'b1,16'h0010, 8'h10,1'b0, 8'h10,1'b0};
        vt[2]  = '{1'b1,1'b1,1'b0,1'b0,16'h0000, 8'h09,1'b0, 8'h09,1'b0};
        vt[3]  = '{1'b1,1'b0,1'b0,1'b1,16'h0000, 8'h00,1'b0, 8'h00,1'b0};
        vt[4]  = '{1'b1,1'b1,1'b0,1'b0,16'h0000, 8'h99,1'b1, 8'h00,1'b1};
        vt[5]  = '{1'b1,1'b0,1'b0,1'b0,16'h0000, 8'h99,1'b0, 8'h00,1'b0};
        vt[6]  = '{1'b1,1'b0,1'b1,1'b1,16'h0098, 8'h98,1'b0, 8'h98,1'b0};
        vt[7]  = '{1'b1,1'b1,1'b1,1'b0,16'h0000, 8'h99,1'b0, 8'h99,1'b0};
        vt[8]  = '{1'b1,1'b1,1'b1,1'b0,16'h0000, 8'h00,1'b1, 8'h99,1'b1};
        vt[9]  = '{1'b1,1'b1,1'b1,1'b0,16'h0000, 8'h01,1'b0, 8'h99,1'b1};
        vt[10] = '{1'b1,1'b1,1'b1,1'b1,16'h00A7, 8'h07,1'b0, 8'h07,1'b0};
        vt[11] = '{1'b1,1'b0,1'b1,1'b1,16'h003F, 8'h30,1'b0, 8'h30,1'b0};
        vt[12] = '{1'b1,1'b1,1'b0,1'b0,16'h0000, 8'h29,1'b0, 8'h29,1'b0};
        vt[13] = '{1'b0,1'b1,1'b1,1'b0,16'h0000, 8'h00,1'b0, 8'h00,1'b0};
        vt[14] = '{1'b1,1'b1,1'b1,1'b0,16'h0000, 8'h01,1'b0, 8'h01,1'b0};

        rst_n = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; ld = '0;
        m_val = '{0, 0, 0}; m_tc = '{0, 0, 0};
        #1;

        for (int i = 0; i < 15; i++) begin
            step(vt[i].r, vt[i].e, vt[i].u, vt[i].l, vt[i].d);
            chk($sformatf("vec%0d c2w", i), {24'd0, c2w}, {24'd0, vt[i].e2w});
            chk($sformatf("vec%0d t2w", i), {31'd0, t2w}, {31'd0, vt[i].t2w});
            chk($sformatf("vec%0d c2s", i), {24'd0, c2s}, {24'd0, vt[i].e2s});
            chk($sformatf("vec%0d t2s", i), {31'd0, t2s}, {31'd0, vt[i].t2s});
        end

        // Reset pulse that never sees a clock edge must not disturb the count.
        en = 1'b0; load = 1'b0; rst_n = 1'b0;
        #3;
        chk("rst_no_edge c2w", {24'd0, c2w}, 32'h01);
        rst_n = 1'b1;
        #1;

        // Full 100-step up run on the 2-digit wrap counter.
        step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
        for (int i = 1; i <= 100; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
            chk($sformatf("run%0d c2w", i), {24'd0, c2w}, {16'd0, int2bcd(i % 100)});
            chk($sformatf("run%0d t2w", i), {31'd0, t2w}, ((i % 100) == 0) ? 32'd1 : 32'd0);
        end

        // Saturate mode: down at zero is blocked and tc stays high while held.
        step(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        chk("sat_dn0 c2s", {24'd0, c2s}, 32'h00);
        chk("sat_dn0 t2s", {31'd0, t2s}, 32'd1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        chk("sat_dn1 t2s", {31'd0, t2s}, 32'd1);

        // Four-digit ripple carry and borrow across several digits at once.
        step(1'b1, 1'b0, 1'b1, 1'b1, 16'h0999);
        step(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
        chk("d4 carry", {16'd0, c4}, 32'h1000);
        step(1'b1, 1'b0, 1'b0, 1'b1, 16'h1000);
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        chk("d4 borrow", {16'd0, c4}, 32'h0999);
        step(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        chk("d4 wrap", {16'd0, c4}, 32'h9999);
        chk("d4 wrap tc", {31'd0, t4}, 32'd1);

        // Randomised traffic against the integer model.
        for (int i = 0; i < 600; i++) begin
            logic r, e, u, l;
            logic [15:0] d;
            r = ($urandom_range(0, 49) != 0);
            l = ($urandom_range(0, 7) == 0);
            e = ($urandom_range(0, 3) != 0);
            u = ($urandom_range(0, 1) != 0);
            d = 16'($urandom);
            if ($urandom_range(0, 3) == 0) d = 16'h9999;
            step(r, e, u, l, d);
            chk_model($sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
